// File: rtl/coin_map_ctrl.sv
// Per-tile coin bitmap for the maze: swept in from the tile-map ROM, cleared as Pac-Man eats,
// with score, coins-left and level-clear tracking plus a registered read port for the renderer.
`timescale 1ns/1ps
module coin_map_ctrl #(
    parameter int MAP_W     = 48,
    parameter int MAP_H     = 27,
    parameter int AW        = 11,
    parameter int COIN_CODE = 2,
    parameter int ROM_LAT   = 1,
    parameter int SCORE_W   = 16,
    parameter int COIN_PTS  = 10
) (
    input  logic               clk_pix,
    input  logic               rstn,
    input  logic               restart,
    output logic [AW-1:0]      rom_addr,
    input  logic [3:0]         rom_code,
    output logic               init_done,
    input  logic [AW-1:0]      rd_addr,
    output logic               rd_coin,
    input  logic               eat_valid,
    input  logic [AW-1:0]      eat_addr,
    output logic               eat_ready,
    output logic               coin_eaten,
    output logic [SCORE_W-1:0] score,
    output logic [AW:0]        coins_left,
    output logic               level_clear
);

    localparam int N  = MAP_W * MAP_H;
    localparam int CW = AW + 1;
    localparam logic [AW:0]        N_W       = CW'(N);
    localparam logic [AW:0]        LAST_CNT  = CW'(N + ROM_LAT - 1);
    localparam logic [AW:0]        LAT_W     = CW'(ROM_LAT);
    localparam logic [AW:0]        ONE_W     = CW'(1);
    localparam logic [AW-1:0]      LAST_ADDR = AW'(N - 1);
    localparam logic [SCORE_W-1:0] PTS       = SCORE_W'(COIN_PTS);
    localparam logic [3:0]         COIN_W    = 4'(COIN_CODE);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t               state_q, state_d;
    logic [AW:0]          cnt_q, cnt_d;
    logic [AW-1:0]        rom_addr_q, rom_addr_d;
    // Sized to the full address space so every index is in range; entries >= N stay 0.
    logic [2**AW-1:0]     bitmap_q, bitmap_d;
    logic [AW:0]          coins_left_q, coins_left_d;
    logic [AW:0]          total_q, total_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 eaten_q, eaten_d;
    logic                 rd_coin_q, rd_coin_d;
    logic                 level_clear_q, level_clear_d;

    logic [AW:0]          wr_idx;
    logic [AW:0]          cnt_inc;
    logic [SCORE_W:0]     score_sum;

    always_ff @(posedge clk_pix or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_INIT;
            cnt_q         <= '0;
            rom_addr_q    <= '0;
            bitmap_q      <= '0;
            coins_left_q  <= '0;
            total_q       <= '0;
            score_q       <= '0;
            eaten_q       <= 1'b0;
            rd_coin_q     <= 1'b0;
            level_clear_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rom_addr_q    <= rom_addr_d;
            bitmap_q      <= bitmap_d;
            coins_left_q  <= coins_left_d;
            total_q       <= total_d;
            score_q       <= score_d;
            eaten_q       <= eaten_d;
            rd_coin_q     <= rd_coin_d;
            level_clear_q <= level_clear_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rom_addr_d   = rom_addr_q;
        bitmap_d     = bitmap_q;
        coins_left_d = coins_left_q;
        total_d      = total_q;
        score_d      = score_q;
        eaten_d      = 1'b0;
        wr_idx       = cnt_q - LAT_W;
        cnt_inc      = cnt_q + ONE_W;
        score_sum    = {1'b0, score_q} + {1'b0, PTS};

        case (state_q)
            S_INIT: begin
                if (restart) begin
                    cnt_d        = '0;
                    rom_addr_d   = '0;
                    coins_left_d = '0;
                    total_d      = '0;
                end else begin
                    // ROM data for sweep address k arrives ROM_LAT cycles after it was driven.
                    if (cnt_q >= LAT_W) begin
                        if (rom_code == COIN_W) begin
                            bitmap_d[wr_idx[AW-1:0]] = 1'b1;
                            coins_left_d             = coins_left_q + ONE_W;
                            total_d                  = total_q + ONE_W;
                        end else begin
                            bitmap_d[wr_idx[AW-1:0]] = 1'b0;
                        end
                    end
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_RUN;
                    end else begin
                        cnt_d      = cnt_inc;
                        rom_addr_d = (cnt_inc < N_W) ? cnt_inc[AW-1:0] : LAST_ADDR;
                    end
                end
            end
            S_RUN: begin
                if (restart) begin
                    state_d      = S_INIT;
                    cnt_d        = '0;
                    rom_addr_d   = '0;
                    coins_left_d = '0;
                    total_d      = '0;
                end else if (eat_valid && ({1'b0, eat_addr} < N_W) && bitmap_q[eat_addr]) begin
                    bitmap_d[eat_addr] = 1'b0;
                    eaten_d            = 1'b1;
                    coins_left_d       = coins_left_q - ONE_W;
                    score_d            = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // The read uses the pre-update bitmap, so a same-cycle eat still reads back the coin.
    assign rd_coin_d     = ({1'b0, rd_addr} < N_W) ? bitmap_q[rd_addr] : 1'b0;
    assign level_clear_d = (state_q == S_RUN) && !restart
                           && (coins_left_q == '0) && (total_q != '0);

    assign rom_addr    = rom_addr_q;
    assign init_done   = (state_q == S_RUN);
    assign eat_ready   = (state_q == S_RUN);
    assign rd_coin     = rd_coin_q;
    assign coin_eaten  = eaten_q;
    assign score       = score_q;
    assign coins_left  = coins_left_q;
    assign level_clear = level_clear_q;

endmodule

// File: tb/tb_coin_map_ctrl.sv
// Directed bench for coin_map_ctrl on an 4x2 map; a second narrow-score instance covers saturation.
`timescale 1ns/1ps
module tb_coin_map_ctrl;

    localparam int AW  = 4;
    localparam int SW  = 16;
    localparam int SWS = 5;

    logic           clk_pix = 1'b0;
    logic           rstn;
    logic           restart;
    logic [AW-1:0]  rom_addr;
    logic [3:0]     rom_code = 4'd0;
    logic           init_done;
    logic [AW-1:0]  rd_addr;
    logic           rd_coin;
    logic           eat_valid;
    logic [AW-1:0]  eat_addr;
    logic           eat_ready;
    logic           coin_eaten;
    logic [SW-1:0]  score;
    logic [AW:0]    coins_left;
    logic           level_clear;

    logic [AW-1:0]  rom_addr_s;
    logic           init_done_s, rd_coin_s, eat_ready_s, coin_eaten_s, level_clear_s;
    logic [SWS-1:0] score_s;
    logic [AW:0]    coins_left_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_pix = ~clk_pix;

    coin_map_ctrl #(.MAP_W(4), .MAP_H(2), .AW(AW), .COIN_CODE(2), .ROM_LAT(1),
                    .SCORE_W(SW), .COIN_PTS(10)) dut (
        .clk_pix(clk_pix), .rstn(rstn), .restart(restart), .rom_addr(rom_addr),
        .rom_code(rom_code), .init_done(init_done), .rd_addr(rd_addr), .rd_coin(rd_coin),
        .eat_valid(eat_valid), .eat_addr(eat_addr), .eat_ready(eat_ready),
        .coin_eaten(coin_eaten), .score(score), .coins_left(coins_left),
        .level_clear(level_clear)
    );

    coin_map_ctrl #(.MAP_W(4), .MAP_H(2), .AW(AW), .COIN_CODE(2), .ROM_LAT(1),
                    .SCORE_W(SWS), .COIN_PTS(10)) dut_sat (
        .clk_pix(clk_pix), .rstn(rstn), .restart(restart), .rom_addr(rom_addr_s),
        .rom_code(rom_code), .init_done(init_done_s), .rd_addr(rd_addr), .rd_coin(rd_coin_s),
        .eat_valid(eat_valid), .eat_addr(eat_addr), .eat_ready(eat_ready_s),
        .coin_eaten(coin_eaten_s), .score(score_s), .coins_left(coins_left_s),
        .level_clear(level_clear_s)
    );

    // Tile-map ROM with one cycle of read latency.
    logic [3:0] rom_mem [0:7] = '{4'd1, 4'd2, 4'd2, 4'd0, 4'd2, 4'd1, 4'd2, 4'd0};
    always @(posedge clk_pix) rom_code <= (rom_addr < 4'd8) ? rom_mem[rom_addr[2:0]] : 4'd0;

    typedef struct { logic [AW-1:0] addr; logic coin; } rd_vec_t;
    typedef struct { logic [AW-1:0] addr; logic pulse; logic [SW-1:0] score; logic [AW:0] left; } eat_vec_t;

    rd_vec_t  rtab [10];
    eat_vec_t etab [5];

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " rom_addr"}, 32'(rom_addr), 0);
        chk({tag, " init_done"}, 32'(init_done), 0);
        chk({tag, " eat_ready"}, 32'(eat_ready), 0);
        chk({tag, " rd_coin"}, 32'(rd_coin), 0);
        chk({tag, " coin_eaten"}, 32'(coin_eaten), 0);
        chk({tag, " score"}, 32'(score), 0);
        chk({tag, " coins_left"}, 32'(coins_left), 0);
        chk({tag, " level_clear"}, 32'(level_clear), 0);
        chk({tag, " score_sat"}, 32'(score_s), 0);
    endtask

    // Called at INIT cycle 0: expects the 8-address sweep and init_done at cycle 9.
    task automatic sweep_check(input string tag);
        for (int k = 0; k < 8; k++) begin
            chk({tag, " rom_addr"}, 32'(rom_addr), 32'(k));
            chk({tag, " init_low"}, 32'(init_done), 0);
            step();
        end
        chk({tag, " init_low_c8"}, 32'(init_done), 0);
        chk({tag, " rom_addr_hold"}, 32'(rom_addr), 7);
        step();
        chk({tag, " init_done_c9"}, 32'(init_done), 1);
        chk({tag, " eat_ready"}, 32'(eat_ready), 1);
        chk({tag, " coins_left"}, 32'(coins_left), 4);
        $display("sweep %s: init_done=%0d coins_left=%0d score=%0d", tag, init_done, coins_left, score);
    endtask

    task automatic read_table(input string tag);
        for (int i = 0; i < 10; i++) begin
            rd_addr = rtab[i].addr;
            step();
            $display("read %s: addr=%0d rd_coin=%0d", tag, rtab[i].addr, rd_coin);
            chk({tag, " rd_coin"}, 32'(rd_coin), 32'(rtab[i].coin));
        end
    endtask

    initial begin
        logic [7:0] bits;
        int pulses;
        bits = 8'b0101_0110;
        for (int i = 0; i < 8; i++) begin
            rtab[i].addr = AW'(i);
            rtab[i].coin = bits[i];
        end
        rtab[8] = '{addr: 4'd9,  coin: 1'b0};
        rtab[9] = '{addr: 4'd15, coin: 1'b0};
        etab[0] = '{addr: 4'd3, pulse: 1'b0, score: 16'd10, left: 5'd3};
        etab[1] = '{addr: 4'd9, pulse: 1'b0, score: 16'd10, left: 5'd3};
        etab[2] = '{addr: 4'd1, pulse: 1'b1, score: 16'd20, left: 5'd2};
        etab[3] = '{addr: 4'd4, pulse: 1'b1, score: 16'd30, left: 5'd1};
        etab[4] = '{addr: 4'd6, pulse: 1'b1, score: 16'd40, left: 5'd0};

        rstn = 1'b0; restart = 1'b0; rd_addr = '0; eat_valid = 1'b0; eat_addr = '0;
        repeat (3) @(posedge clk_pix);
        #1;
        chk_reset_vals("reset");

        // T1/T2: sweep after release, then bitmap and out-of-range reads.
        rstn = 1'b1;
        sweep_check("t1");
        read_table("t2");

        // T3: held eat on one tile gives a single pulse.
        eat_valid = 1'b1; eat_addr = 4'd2; pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) chk("t3 first_pulse", 32'(coin_eaten), 1);
            pulses += int'(coin_eaten);
        end
        eat_valid = 1'b0;
        step();
        pulses += int'(coin_eaten);
        $display("eat t3: addr=2 held pulses=%0d score=%0d left=%0d", pulses, score, coins_left);
        chk("t3 pulses", 32'(pulses), 1);
        chk("t3 score", 32'(score), 10);
        chk("t3 coins_left", 32'(coins_left), 3);
        rd_addr = 4'd2;
        step();
        chk("t3 rd_coin_after", 32'(rd_coin), 0);

        // T4: empty tile, out-of-range tile, then the remaining coins (read same cycle as eat).
        for (int i = 0; i < 5; i++) begin
            eat_valid = 1'b1; eat_addr = etab[i].addr; rd_addr = etab[i].addr;
            step();
            eat_valid = 1'b0;
            $display("eat t4: addr=%0d pulse=%0d score=%0d left=%0d", etab[i].addr, coin_eaten, score, coins_left);
            chk("t4 pulse", 32'(coin_eaten), 32'(etab[i].pulse));
            chk("t4 rd_pre_clear", 32'(rd_coin), 32'(etab[i].pulse));
            chk("t4 score", 32'(score), 32'(etab[i].score));
            chk("t4 coins_left", 32'(coins_left), 32'(etab[i].left));
            chk("t4 level_clear_early", 32'(level_clear), 0);
        end
        step();
        chk("t4 pulse_gone", 32'(coin_eaten), 0);
        chk("t4 level_clear", 32'(level_clear), 1);
        chk("t4 score_saturated", 32'(score_s), 31);

        // T5: restart with a same-cycle eat; score survives.
        restart = 1'b1; eat_valid = 1'b1; eat_addr = 4'd1;
        step();
        restart = 1'b0; eat_valid = 1'b0;
        chk("t5 no_pulse", 32'(coin_eaten), 0);
        chk("t5 level_clear", 32'(level_clear), 0);
        chk("t5 coins_cleared", 32'(coins_left), 0);
        sweep_check("t5");
        chk("t5 score_kept", 32'(score), 40);
        chk("t5 score_sat_kept", 32'(score_s), 31);
        chk("t5 level_clear_after", 32'(level_clear), 0);
        read_table("t5");

        // Restart drops an eat on a live coin; a second restart mid-INIT resweeps from 0.
        restart = 1'b1; eat_valid = 1'b1; eat_addr = 4'd2;
        step();
        restart = 1'b0; eat_valid = 1'b0;
        chk("rs drop_pulse", 32'(coin_eaten), 0);
        chk("rs drop_score", 32'(score), 40);
        repeat (3) step();
        chk("rs mid_rom_addr", 32'(rom_addr), 3);
        chk("rs mid_coins", 32'(coins_left), 1);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("rs reinit_coins", 32'(coins_left), 0);
        sweep_check("rs");

        // T6: async reset at INIT cycle 4.
        restart = 1'b1;
        step();
        restart = 1'b0; rd_addr = 4'd1;
        repeat (4) step();
        chk("t6 rom_addr_c4", 32'(rom_addr), 4);
        chk("t6 rd_coin_c4", 32'(rd_coin), 1);
        chk("t6 coins_c4", 32'(coins_left), 2);
        #2 rstn = 1'b0;
        #1;
        chk_reset_vals("t6 async");
        repeat (2) @(posedge clk_pix);
        #1;
        rstn = 1'b1;
        sweep_check("t6");
        chk("t6 score_zero", 32'(score), 0);
        read_table("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
